rgb_cycle_monitor: RTL

//   Receive-side checker for the 6-step active-low RGB colour cycle driven onto the on-board LED.

---
 rtl/rgb_cycle_monitor.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rgb_cycle_monitor.sv
// Receive-side checker for the active-low RGB colour cycle: synchronises, debounces and decodes
// the LED lines, then verifies step order and per-step dwell time.
module rgb_cycle_monitor #(
  parameter int unsigned STEP_CYCLES = 2000000,
  parameter int unsigned TOL_CYCLES  = 1000,
  parameter int unsigned SETTLE      = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rgb_r_ni,
  input  logic       rgb_g_ni,
  input  logic       rgb_b_ni,
  input  logic       err_clr_i,
  output logic [2:0] color_idx_o,
  output logic       color_valid_o,
  output logic       step_pulse_o,
  output logic       cycle_done_o,
  output logic [7:0] cycle_count_o,
  output logic       seq_error_o,
  output logic       dwell_error_o
);

  localparam int unsigned DwellMax = STEP_CYCLES + TOL_CYCLES + 1;
  localparam int unsigned DwellMin = STEP_CYCLES - TOL_CYCLES;
  localparam int unsigned DwellW   = $clog2(DwellMax + 1);
  localparam int unsigned SetW     = $clog2(SETTLE + 1);

  localparam logic [DwellW-1:0] DwellMaxC = DwellW'(DwellMax);
  localparam logic [DwellW-1:0] DwellTopC = DwellW'(DwellMax - 1);
  localparam logic [DwellW-1:0] DwellMinC = DwellW'(DwellMin);
  localparam logic [SetW-1:0]   SettleC   = SetW'(SETTLE);
  localparam logic [2:0]        NoColor   = 3'd7;

  typedef enum logic [1:0] {StIdle, StLock, StTrack} state_e;

  state_e            state_q, state_d;
  logic [2:0]        meta_q, sync_q;
  logic [2:0]        cand_q, cand_d;
  logic [SetW-1:0]   cnt_q, cnt_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        count_q, count_d;
  logic              step_q, step_d, cdone_q, cdone_d;
  logic              seq_q, seq_d, derr_q, derr_d;
  logic              seq_set, derr_set;
  logic [2:0]        code, nxt;
  logic              accept, code_valid;

  // Lit pattern {R,G,B} to step index.
  always_comb begin
    unique case (sync_q)
      3'b100:  code = 3'd0;
      3'b110:  code = 3'd1;
      3'b010:  code = 3'd2;
      3'b011:  code = 3'd3;
      3'b001:  code = 3'd4;
      3'b101:  code = 3'd5;
      default: code = NoColor;
    endcase
  end

  assign code_valid = (code != NoColor);
  assign nxt        = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

  // The accepted code always equals idx_q, so a change is any settled code differing from it.
  always_comb begin
    cand_d = code;
    if (code == cand_q) begin
      cnt_d = (cnt_q == SettleC) ? cnt_q : cnt_q + SetW'(1);
    end else begin
      cnt_d = SetW'(1);
    end
    accept = (cnt_d == SettleC) && (code != idx_q);
  end

  always_comb begin
    if (accept) begin
      dwell_d = DwellW'(1);
    end else if (dwell_q != DwellMaxC) begin
      dwell_d = dwell_q + DwellW'(1);
    end else begin
      dwell_d = dwell_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    step_d   = 1'b0;
    cdone_d  = 1'b0;
    seq_set  = 1'b0;
    derr_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && code_valid) begin
          state_d = StLock;
          idx_d   = code;
        end
      end
      StLock: begin
        if (accept) begin
          if (code == nxt) begin
            state_d = StTrack;
            idx_d   = code;
            step_d  = 1'b1;
            cdone_d = (code == 3'd0);
          end else if (code_valid) begin
            seq_set = 1'b1;
            idx_d   = code;
          end else begin
            state_d = StIdle;
            idx_d   = NoColor;
          end
        end
      end
      StTrack: begin
        if (accept) begin
          if (code == nxt) begin
            idx_d  = code;
            step_d = 1'b1;
            if (code == 3'd0) begin
              cdone_d = 1'b1;
              count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            end
            derr_set = (dwell_q < DwellMinC);
          end else if (code_valid) begin
            seq_set = 1'b1;
            state_d = StLock;
            idx_d   = code;
          end else begin
            seq_set = 1'b1;
            state_d = StIdle;
            idx_d   = NoColor;
          end
        end else if (dwell_q == DwellTopC) begin
          // Flag once, on the cycle the dwell register reaches its saturation value.
          derr_set = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = NoColor;
      end
    endcase
    seq_d  = (seq_q & ~err_clr_i) | seq_set;
    derr_d = (derr_q & ~err_clr_i) | derr_set;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q  <= 3'b000;
      sync_q  <= 3'b000;
      cand_q  <= NoColor;
      cnt_q   <= '0;
      dwell_q <= '0;
      state_q <= StIdle;
      idx_q   <= NoColor;
      count_q <= 8'd0;
      step_q  <= 1'b0;
      cdone_q <= 1'b0;
      seq_q   <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      meta_q  <= ~{rgb_r_ni, rgb_g_ni, rgb_b_ni};
      sync_q  <= meta_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      step_q  <= step_d;
      cdone_q <= cdone_d;
      seq_q   <= seq_d;
      derr_q  <= derr_d;
    end
  end

  assign color_idx_o   = idx_q;
  assign color_valid_o = (idx_q != NoColor);
  assign step_pulse_o  = step_q;
  assign cycle_done_o  = cdone_q;
  assign cycle_count_o = count_q;
  assign seq_error_o   = seq_q;
  assign dwell_error_o = derr_q;

endmodule
